// File: rtl/lpc_reg_arbiter.sv
// Round-robin arbiter giving the LPC host and the BMC side-band access to one register bank.
// Optional macro LPC_ARB_BMC_WP_EN: BmcWp blocks host writes to register 8'h18.
module lpc_reg_arbiter #(
  parameter logic [7:0] REG_LAST    = 8'h1F,
  parameter int         REL_TIMEOUT = 16
) (
  input  logic       LpcClock,
  input  logic       PciReset,
  input  logic       HostReq,
  input  logic       HostWr,
  input  logic [7:0] HostAddr,
  input  logic [7:0] HostData,
  output logic       HostAck,
  input  logic       BmcReq,
  input  logic       BmcWr,
  input  logic [7:0] BmcAddr,
  input  logic [7:0] BmcData,
  output logic       BmcAck,
  input  logic       BmcWp,
  input  logic [7:0] RegRdData,
  output logic [7:0] Addr,
  output logic       Wr,
  output logic [7:0] DataWrSW,
  output logic [7:0] RdData,
  output logic       GrantHost,
  output logic       GrantBmc
);

  // state  | meaning
  // IDLE   | no owner, arbitrating
  // SETUP  | winner latched, grant high
  // ACCESS | register bank write / read capture
  // DONE   | ack pulsed, waiting for the owner to release
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  localparam int CW = $clog2(REL_TIMEOUT + 1);

  state_t        state, state_nxt;
  logic          owner_bmc;     // current owner, doubles as last-owner flag
  logic          wr_lat;
  logic          ack_q;
  logic [CW-1:0] rel_cnt;
  logic          pick_bmc;
  logic          owner_req;
  logic          in_range;
  logic          wp_block;

  assign pick_bmc  = BmcReq && (!HostReq || !owner_bmc);
  assign owner_req = owner_bmc ? BmcReq : HostReq;
  assign in_range  = (Addr <= REG_LAST);

`ifdef LPC_ARB_BMC_WP_EN
  assign wp_block = !owner_bmc && (Addr == 8'h18) && BmcWp;
`else
  logic unused_bmc_wp;
  assign unused_bmc_wp = BmcWp;
  assign wp_block      = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (HostReq || BmcReq) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  state_nxt = DONE;
      DONE:    if (!owner_req || rel_cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge LpcClock) begin
    if (PciReset) begin
      state     <= IDLE;
      owner_bmc <= 1'b1;
      wr_lat    <= 1'b0;
      ack_q     <= 1'b0;
      rel_cnt   <= '0;
      Addr      <= 8'h00;
      DataWrSW  <= 8'h00;
      RdData    <= 8'h00;
    end else begin
      state <= state_nxt;
      ack_q <= (state == ACCESS);
      if (state == IDLE && state_nxt == SETUP) begin
        owner_bmc <= pick_bmc;
        Addr      <= pick_bmc ? BmcAddr : HostAddr;
        DataWrSW  <= pick_bmc ? BmcData : HostData;
        wr_lat    <= pick_bmc ? BmcWr   : HostWr;
      end
      if (state == ACCESS) begin
        rel_cnt <= CW'(REL_TIMEOUT - 1);
        if (!wr_lat) RdData <= in_range ? RegRdData : 8'hFF;
      end else if (state == DONE && rel_cnt != '0) begin
        rel_cnt <= rel_cnt - 1'b1;
      end
    end
  end

  // Gated by PciReset so a reset landing in ACCESS never commits the write.
  assign Wr        = (state == ACCESS) && wr_lat && in_range && !wp_block && !PciReset;
  assign HostAck   = ack_q && !owner_bmc;
  assign BmcAck    = ack_q && owner_bmc;
  assign GrantHost = (state != IDLE) && !owner_bmc;
  assign GrantBmc  = (state != IDLE) && owner_bmc;

endmodule

// File: tb/tb_lpc_reg_arbiter.sv
// Directed self-checking bench for lpc_reg_arbiter with a tiny register-bank model.
module tb_lpc_reg_arbiter;
  logic       LpcClock = 1'b0;
  logic       PciReset = 1'b1;
  logic       HostReq = 1'b0, HostWr = 1'b0;
  logic [7:0] HostAddr = 8'h00, HostData = 8'h00;
  logic       BmcReq = 1'b0, BmcWr = 1'b0;
  logic [7:0] BmcAddr = 8'h00, BmcData = 8'h00;
  logic       BmcWp = 1'b0;
  logic [7:0] RegRdData;
  logic       HostAck, BmcAck, Wr, GrantHost, GrantBmc;
  logic [7:0] Addr, DataWrSW, RdData;

  int         npass = 0;
  int         ntot  = 0;
  int         wr_cnt = 0;
  logic [7:0] wr_addr = 8'h00, wr_data = 8'h00;
  int         wp_exp_cnt;
  logic       wp_exp_wr;

  lpc_reg_arbiter dut (
    .LpcClock(LpcClock), .PciReset(PciReset),
    .HostReq(HostReq), .HostWr(HostWr), .HostAddr(HostAddr), .HostData(HostData), .HostAck(HostAck),
    .BmcReq(BmcReq), .BmcWr(BmcWr), .BmcAddr(BmcAddr), .BmcData(BmcData), .BmcAck(BmcAck),
    .BmcWp(BmcWp), .RegRdData(RegRdData),
    .Addr(Addr), .Wr(Wr), .DataWrSW(DataWrSW), .RdData(RdData),
    .GrantHost(GrantHost), .GrantBmc(GrantBmc)
  );

  always #15 LpcClock = ~LpcClock;

  assign RegRdData = (Addr == 8'h01) ? 8'hAA : (Addr == 8'h02) ? 8'hBB : 8'h00;

  always @(posedge LpcClock) begin
    if (Wr) begin
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= Addr;
      wr_data <= DataWrSW;
    end
  end

  task automatic step();
    @(posedge LpcClock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_grant_host"}, 32'(GrantHost), 32'd0);
    chk({tag, "_grant_bmc"},  32'(GrantBmc),  32'd0);
    chk({tag, "_host_ack"},   32'(HostAck),   32'd0);
    chk({tag, "_bmc_ack"},    32'(BmcAck),    32'd0);
    chk({tag, "_wr"},         32'(Wr),        32'd0);
    chk({tag, "_addr"},       32'(Addr),      32'h00);
    chk({tag, "_data_wr"},    32'(DataWrSW),  32'h00);
    chk({tag, "_rd_data"},    32'(RdData),    32'h00);
  endtask

  initial begin
`ifdef LPC_ARB_BMC_WP_EN
    wp_exp_wr  = 1'b0;
    wp_exp_cnt = 2;
`else
    wp_exp_wr  = 1'b1;
    wp_exp_cnt = 3;
`endif
    step(); step();
    chk_reset_vals("reset");

    // first tie after reset: host wins
    PciReset = 1'b0;
    HostReq = 1; HostWr = 0; HostAddr = 8'h01;
    BmcReq  = 1; BmcWr  = 0; BmcAddr  = 8'h02;
    step();
    chk("tie1_grant_host", 32'(GrantHost), 1);
    chk("tie1_grant_bmc",  32'(GrantBmc),  0);
    chk("tie1_addr",       32'(Addr),      32'h01);
    step();
    chk("tie1_rd_no_wr",   32'(Wr),        0);
    step();
    chk("tie1_host_ack",   32'(HostAck),   1);
    chk("tie1_bmc_no_ack", 32'(BmcAck),    0);
    chk("tie1_rd_data",    32'(RdData),    32'hAA);
    HostReq = 0;
    step();
    chk("tie1_release_host", 32'(GrantHost), 0);
    chk("tie1_release_bmc",  32'(GrantBmc),  0);
    step();
    chk("tie1_bmc_grant",  32'(GrantBmc),  1);
    chk("tie1_bmc_addr",   32'(Addr),      32'h02);
    step(); step();
    chk("tie1_bmc_ack",    32'(BmcAck),    1);
    chk("tie1_bmc_rd",     32'(RdData),    32'hBB);
    BmcReq = 0;
    step();

    // host write with address/data changing after latch
    HostReq = 1; HostWr = 1; HostAddr = 8'h0E; HostData = 8'h05;
    step();
    chk("wr_grant", 32'(GrantHost), 1);
    chk("wr_setup_no_wr", 32'(Wr), 0);
    HostAddr = 8'h33; HostData = 8'h11;
    step();
    chk("wr_pulse", 32'(Wr), 1);
    chk("wr_addr",  32'(Addr), 32'h0E);
    chk("wr_data",  32'(DataWrSW), 32'h05);
    step();
    chk("wr_ack",   32'(HostAck), 1);
    chk("wr_done_no_wr", 32'(Wr), 0);
    chk("wr_rd_held", 32'(RdData), 32'hBB);
    HostReq = 0;
    step();
    chk("wr_cnt",   32'(wr_cnt), 1);
    chk("wr_bank_addr", 32'(wr_addr), 32'h0E);
    chk("wr_bank_data", 32'(wr_data), 32'h05);
    chk("wr_idle_addr_hold", 32'(Addr), 32'h0E);

    // second tie: host served last, so BMC wins; BMC address out of range
    HostReq = 1; HostWr = 0; HostAddr = 8'h02;
    BmcReq  = 1; BmcWr  = 0; BmcAddr  = 8'h25;
    step();
    chk("tie2_grant_bmc",  32'(GrantBmc),  1);
    chk("tie2_grant_host", 32'(GrantHost), 0);
    step();
    chk("oor_no_wr", 32'(Wr), 0);
    step();
    chk("oor_bmc_ack", 32'(BmcAck), 1);
    chk("oor_host_no_ack", 32'(HostAck), 0);
    chk("oor_rd_ff", 32'(RdData), 32'hFF);
    BmcReq = 0;
    step(); step();
    chk("tie2_host_grant", 32'(GrantHost), 1);
    step(); step();
    chk("tie2_host_ack", 32'(HostAck), 1);
    chk("tie2_host_rd",  32'(RdData), 32'hBB);
    HostReq = 0;
    step();

    // BMC in-range read
    BmcReq = 1; BmcAddr = 8'h01;
    step(); step(); step();
    chk("bmc_rd_ack", 32'(BmcAck), 1);
    chk("bmc_rd_aa",  32'(RdData), 32'hAA);
    BmcReq = 0;
    step();

    // owner holds Req: release after REL_TIMEOUT DONE cycles, pending BMC next
    HostReq = 1; HostWr = 1; HostAddr = 8'h03; HostData = 8'h77;
    step();
    BmcReq = 1; BmcWr = 0; BmcAddr = 8'h02;
    step();
    chk("to_wr", 32'(Wr), 1);
    step();
    chk("to_ack", 32'(HostAck), 1);
    for (int i = 0; i < 15; i++) step();
    chk("to_still_granted", 32'(GrantHost), 1);
    chk("to_ack_once", 32'(HostAck), 0);
    chk("to_bmc_held_off", 32'(GrantBmc), 0);
    step();
    chk("to_released", 32'(GrantHost), 0);
    step();
    chk("to_bmc_grant", 32'(GrantBmc), 1);
    HostReq = 0;
    step(); step();
    chk("to_bmc_ack", 32'(BmcAck), 1);
    chk("to_bmc_rd",  32'(RdData), 32'hBB);
    BmcReq = 0;
    step();
    chk("to_wr_cnt", 32'(wr_cnt), 2);

    // reset during ACCESS of a write
    HostReq = 1; HostWr = 1; HostAddr = 8'h04; HostData = 8'h99;
    step(); step();
    chk("rst_pre_wr", 32'(Wr), 1);
    PciReset = 1;
    #1;
    chk("rst_wr_gated", 32'(Wr), 0);
    step();
    chk_reset_vals("rst_mid");
    chk("rst_no_bank_write", 32'(wr_cnt), 2);
    PciReset = 0; HostReq = 0;
    step();
    chk("rst_idle", 32'(GrantHost), 0);

    // write-protected address
    HostReq = 1; HostWr = 1; HostAddr = 8'h18; HostData = 8'h5A; BmcWp = 1;
    step(); step();
    chk("wp_wr", 32'(Wr), 32'(wp_exp_wr));
    step();
    chk("wp_ack", 32'(HostAck), 1);
    HostReq = 0; BmcWp = 0;
    step();
    chk("wp_wr_cnt", 32'(wr_cnt), 32'(wp_exp_cnt));

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
